scanner_lot_sequencer: RTL
==========================

Name: scanner_lot_sequencer

Overview:
Lot-level controller that drives scanner_handler_module through a full exposure lot. Per lot it runs reticle load, then wafer load / expose / wafer unload for each wafer, then reticle unload. It owns the handler's four command lines and the exposure-start handshake, with a per-step watchdog and abort. It sits between the host lot interface and the handler/exposure units.

Parameters:
CNT_W, 8, width of wafer count and wafers_done
TIMEOUT, 64, max cycles any step may wait for its ready/done before erroring
TMR_W, 8, watchdog counter width (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  lot start pulse; sampled only in IDLE
wafer_count  input  CNT_W  wafers in lot; latched when start is accepted
abort  input  1  force error from any active state
clear_err  input  1  leave ERROR to IDLE
wl_ready  input  1  wafer-loader ready from handler
rl_ready  input  1  reticle-loader ready from handler
expose_done  input  1  exposure-complete pulse/level
cmd_wl_load  output  1  to handler
cmd_wl_unload  output  1  to handler
cmd_rl_load  output  1  to handler
cmd_rl_unload  output  1  to handler
expose_start  output  1  one-cycle exposure start pulse
busy  output  1  high in every state except IDLE and ERROR
lot_done  output  1  one-cycle pulse on lot completion
error  output  1  high while in ERROR
err_code  output  2  0 none, 1 handler timeout, 2 expose timeout, 3 abort
wafers_done  output  CNT_W  wafers unloaded in current/last lot

Behaviour:
- All outputs registered. Reset: every cmd_* = 0, expose_start = 0, busy = 0, lot_done = 0, error = 0, err_code = 0, wafers_done = 0, state IDLE. Reset mid-lot drops all commands the cycle reset asserts.
- States: IDLE, RL_LOAD, WL_LOAD, EXPOSE, WL_UNLOAD, RL_UNLOAD, DONE, ERROR.
- IDLE: start=1 and wafer_count!=0 -> latch count, clear wafers_done, go RL_LOAD. wafer_count=0 -> start ignored. start outside IDLE is ignored.
- Command states (RL_LOAD, WL_LOAD, WL_UNLOAD, RL_UNLOAD) have two phases:
  - ARM: own cmd low until the matching ready (rl_ready or wl_ready) is sampled 0. This guarantees the handler timer reset between back-to-back commands.
  - DRIVE: own cmd held 1 until matching ready is sampled 1. Then cmd drops on the same edge and the state advances.
  - At most one cmd_* is ever high.
- Transitions:
  - RL_LOAD -> WL_LOAD.
  - WL_LOAD -> EXPOSE.
  - EXPOSE: pulse expose_start for the first cycle in the state, then wait for expose_done=1 -> WL_UNLOAD. expose_done is ignored in all other states.
  - WL_UNLOAD completion: wafers_done += 1. If the new value == latched count -> RL_UNLOAD, else -> WL_LOAD.
  - RL_UNLOAD -> DONE.
  - DONE: lot_done=1 for one cycle, then IDLE. wafers_done holds its value.
- Watchdog: cleared on every state entry; counts in ARM, DRIVE and EXPOSE wait.
  - Reaching TIMEOUT -> ERROR with err_code 1 (command state) or 2 (EXPOSE).
- abort=1 in any busy state -> ERROR with err_code 3. abort has priority over simultaneous ready/done/timeout.
- ERROR: all cmds 0, busy 0, error 1. clear_err -> IDLE with err_code 0. abort and start are ignored in ERROR. wafers_done is frozen.
- wafers_done saturates only via the count compare; no wrap within a lot.

Test Plan:
- Reset, then start with wafer_count=1 and real handler plus expose model (done 3 cycles after start). Required: cmd order rl_load, wl_load, expose_start, wl_unload, rl_unload. cmd_rl_load high exactly 5 cycles, cmd_wl_load high exactly 6 cycles. One lot_done pulse; wafers_done=1.
- wafer_count=3 -> exactly 3 expose_start pulses, one rl_load and one rl_unload. Every wl command rises only after wl_ready was sampled 0 (no back-to-back carryover); wafers_done=3.
- Tie wl_ready=0 permanently -> 64 cycles after entering WL_LOAD: error=1, err_code=1, all cmds 0. Then clear_err -> IDLE, error=0.
- Withhold expose_done -> err_code=2 after TIMEOUT. Separately, abort during WL_UNLOAD DRIVE on the same cycle as wl_ready=1 -> err_code=3 and wafers_done not incremented.
- start while busy and start with wafer_count=0 -> no effect. Reset asserted mid-EXPOSE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/scanner_lot_sequencer.sv
// ----------------------------------------------------------------------------
// scanner_lot_sequencer: runs reticle/wafer handling and exposure for one lot.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scanner_lot_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] wafer_count,
  input  logic             abort,
  input  logic             clear_err,
  input  logic             wl_ready,
  input  logic             rl_ready,
  input  logic             expose_done,
  output logic             cmd_wl_load,
  output logic             cmd_wl_unload,
  output logic             cmd_rl_load,
  output logic             cmd_rl_unload,
  output logic             expose_start,
  output logic             busy,
  output logic             lot_done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] wafers_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RL_LOAD   = 3'd1,
    S_WL_LOAD   = 3'd2,
    S_EXPOSE    = 3'd3,
    S_WL_UNLOAD = 3'd4,
    S_RL_UNLOAD = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_drive;
  logic             w_drive_nx;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nx;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nx;
  logic [CNT_W-1:0] r_wafers;
  logic [CNT_W-1:0] w_wafers_nx;
  logic [CNT_W-1:0] w_wafers_inc;
  logic [1:0]       r_err_code;
  logic [1:0]       w_err_nx;
  logic             r_cmd_wl_load;
  logic             r_cmd_wl_unload;
  logic             r_cmd_rl_load;
  logic             r_cmd_rl_unload;
  logic             r_expose_start;
  logic             r_busy;
  logic             r_lot_done;
  logic             r_error;
  logic             w_ready;
  logic             w_timeout;
  logic             w_busy_state;

  assign w_ready      = (r_state == S_RL_LOAD || r_state == S_RL_UNLOAD) ? rl_ready : wl_ready;
  assign w_timeout    = (r_tmr == TMR_W'(TIMEOUT - 1));
  assign w_wafers_inc = r_wafers + CNT_W'(1);
  assign w_busy_state = !(r_state == S_IDLE || r_state == S_ERROR);

  always_comb begin
    w_state_nx  = r_state;
    w_drive_nx  = r_drive;
    w_tmr_nx    = r_tmr + TMR_W'(1);
    w_count_nx  = r_count;
    w_wafers_nx = r_wafers;
    w_err_nx    = r_err_code;

    case (r_state)
      S_IDLE: begin
        if (start && wafer_count != '0) begin
          w_state_nx  = S_RL_LOAD;
          w_count_nx  = wafer_count;
          w_wafers_nx = '0;
        end
      end
      // ARM waits for ready low so the handler sees a fresh request; DRIVE
      // holds the command until ready is seen high.
      S_RL_LOAD, S_WL_LOAD, S_WL_UNLOAD, S_RL_UNLOAD: begin
        if (!r_drive) begin
          if (!w_ready) begin
            w_drive_nx = 1'b1;
          end
        end else if (w_ready) begin
          case (r_state)
            S_RL_LOAD: w_state_nx = S_WL_LOAD;
            S_WL_LOAD: w_state_nx = S_EXPOSE;
            S_WL_UNLOAD: begin
              w_wafers_nx = w_wafers_inc;
              w_state_nx  = (w_wafers_inc == r_count) ? S_RL_UNLOAD : S_WL_LOAD;
            end
            default: w_state_nx = S_DONE;
          endcase
        end
        if (w_state_nx == r_state && w_timeout) begin
          w_state_nx = S_ERROR;
          w_err_nx   = 2'd1;
        end
      end
      S_EXPOSE: begin
        if (expose_done) begin
          w_state_nx = S_WL_UNLOAD;
        end else if (w_timeout) begin
          w_state_nx = S_ERROR;
          w_err_nx   = 2'd2;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      S_ERROR: begin
        if (clear_err) begin
          w_state_nx = S_IDLE;
          w_err_nx   = 2'd0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Abort overrides any completion or timeout seen in the same cycle.
    if (w_busy_state && abort) begin
      w_state_nx  = S_ERROR;
      w_err_nx    = 2'd3;
      w_wafers_nx = r_wafers;
    end

    if (w_state_nx != r_state) begin
      w_tmr_nx   = '0;
      w_drive_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_drive         <= 1'b0;
      r_tmr           <= '0;
      r_count         <= '0;
      r_wafers        <= '0;
      r_err_code      <= 2'd0;
      r_cmd_wl_load   <= 1'b0;
      r_cmd_wl_unload <= 1'b0;
      r_cmd_rl_load   <= 1'b0;
      r_cmd_rl_unload <= 1'b0;
      r_expose_start  <= 1'b0;
      r_busy          <= 1'b0;
      r_lot_done      <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_drive         <= w_drive_nx;
      r_tmr           <= w_tmr_nx;
      r_count         <= w_count_nx;
      r_wafers        <= w_wafers_nx;
      r_err_code      <= w_err_nx;
      r_cmd_rl_load   <= (w_state_nx == S_RL_LOAD)   && w_drive_nx;
      r_cmd_wl_load   <= (w_state_nx == S_WL_LOAD)   && w_drive_nx;
      r_cmd_wl_unload <= (w_state_nx == S_WL_UNLOAD) && w_drive_nx;
      r_cmd_rl_unload <= (w_state_nx == S_RL_UNLOAD) && w_drive_nx;
      r_expose_start  <= (w_state_nx == S_EXPOSE) && (r_state != S_EXPOSE);
      r_busy          <= !(w_state_nx == S_IDLE || w_state_nx == S_ERROR);
      r_lot_done      <= (w_state_nx == S_DONE);
      r_error         <= (w_state_nx == S_ERROR);
    end
  end

  assign cmd_wl_load   = r_cmd_wl_load;
  assign cmd_wl_unload = r_cmd_wl_unload;
  assign cmd_rl_load   = r_cmd_rl_load;
  assign cmd_rl_unload = r_cmd_rl_unload;
  assign expose_start  = r_expose_start;
  assign busy          = r_busy;
  assign lot_done      = r_lot_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign wafers_done   = r_wafers;

endmodule

`default_nettype wire
